// File: rtl/xsim_bus_responder_pkg.sv
// rtl/xsim_bus_responder_pkg.sv - shared xSimBus encodings and responder state codes
// Purpose : select-mode, read/write and reset encodings of the xSimBus, plus the
//           responder FSM state type.
// Ports   : none (package).
package xsim_bus_responder_pkg;

    localparam int SELECT_MODE_W = 2;

    localparam logic [SELECT_MODE_W-1:0] SELECT_AS_NONE   = 2'b00;
    localparam logic [SELECT_MODE_W-1:0] SELECT_AS_MASTER = 2'b01;
    localparam logic [SELECT_MODE_W-1:0] SELECT_AS_DEVICE = 2'b10;

    localparam logic RW_INOUT_R = 1'b0;
    localparam logic RW_INOUT_W = 1'b1;

    localparam logic RST_ENABLE = 1'b1;

    typedef enum logic [1:0] {
        RESP_IDLE    = 2'b00,
        RESP_WAIT    = 2'b01,
        RESP_ACK     = 2'b10,
        RESP_RELEASE = 2'b11
    } resp_state_e;

    function automatic logic is_device_request(input logic [SELECT_MODE_W-1:0] sel);
        return sel == SELECT_AS_DEVICE;
    endfunction

endpackage

// File: rtl/xsim_bus_responder_if.sv
// rtl/xsim_bus_responder_if.sv - one device slot of the xSimBus
// Purpose : bundles the slot's select/rw/address/data request lines and the
//           responder's data/ready/error return lines.
// Ports   : master modport drives select_in, rw_in, addr_in, data_in;
//           slave modport drives data_out, ready_out, err_out.
interface xsim_bus_responder_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 27
);
    import xsim_bus_responder_pkg::*;

    logic [SELECT_MODE_W-1:0] select_in;
    logic                     rw_in;
    logic [ADDR_W-1:0]        addr_in;
    logic [DATA_W-1:0]        data_in;
    logic [DATA_W-1:0]        data_out;
    logic                     ready_out;
    logic                     err_out;

    modport master (
        output select_in, rw_in, addr_in, data_in,
        input  data_out, ready_out, err_out
    );

    modport slave (
        input  select_in, rw_in, addr_in, data_in,
        output data_out, ready_out, err_out
    );

endinterface

// File: rtl/xsim_resp_regbank.sv
// rtl/xsim_resp_regbank.sv - responder register bank with bus/local write ports
// Purpose : NREGS x DATA_W registers, a bus write port and a local write port
//           (bus wins on the same index), combinational read mux and a flat view.
// Ports   : clk, rst; bus_we/bus_idx/bus_data; hw_we/hw_idx/hw_data;
//           rd_idx -> rd_data; regs_out (reg i at [i*DATA_W +: DATA_W]).
module xsim_resp_regbank
    import xsim_bus_responder_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int NREGS  = 8,
    localparam int IDX_W  = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bus_we,
    input  logic [IDX_W-1:0]        bus_idx,
    input  logic [DATA_W-1:0]       bus_data,
    input  logic                    hw_we,
    input  logic [IDX_W-1:0]        hw_idx,
    input  logic [DATA_W-1:0]       hw_data,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [DATA_W-1:0]       rd_data,
    output logic [NREGS*DATA_W-1:0] regs_out
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    // Bus write is applied last so it overrides a local write to the same index.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (hw_we && (hw_idx == IDX_W'(i))) begin
                regs_d[i] = hw_data;
            end
            if (bus_we && (bus_idx == IDX_W'(i))) begin
                regs_d[i] = bus_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (rst == RST_ENABLE) begin
                regs_q[i] <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        rd_data = regs_q[rd_idx];
    end

    always_comb begin
        regs_out = '0;
        for (int i = 0; i < NREGS; i++) begin
            regs_out[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

endmodule

// File: rtl/xsim_bus_responder.sv
// rtl/xsim_bus_responder.sv - xSimBus device-side endpoint with wait states
// Purpose : decodes this slot's requests, serves them against a local register
//           bank after WAIT_CYCLES wait states and pulses a one-cycle ack.
// Ports   : clk, rst (sync, active-high); bus (slave modport of the slot);
//           hw_we_in/hw_idx_in/hw_data_in local write port; regs_out flat bank view.
module xsim_bus_responder
    import xsim_bus_responder_pkg::*;
#(
    parameter  int DATA_W      = 8,
    parameter  int ADDR_W      = 27,
    parameter  int NREGS       = 8,
    parameter  int WAIT_CYCLES = 2,
    localparam int IDX_W       = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    xsim_bus_responder_if.slave     bus,
    input  logic                    hw_we_in,
    input  logic [IDX_W-1:0]        hw_idx_in,
    input  logic [DATA_W-1:0]       hw_data_in,
    output logic [NREGS*DATA_W-1:0] regs_out
);

    resp_state_e       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              oor_q, oor_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;

    logic              request;
    logic              commit;
    logic [ADDR_W-1:0] c_addr;
    logic              c_rw;
    logic [DATA_W-1:0] c_data;
    logic              in_range;
    logic              bus_we;
    logic [DATA_W-1:0] rd_data;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q    <= RESP_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            rw_q       <= RW_INOUT_R;
            wdata_q    <= '0;
            oor_q      <= 1'b0;
            data_out_q <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            wdata_q    <= wdata_d;
            oor_q      <= oor_d;
            data_out_q <= data_out_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        request = is_device_request(bus.select_in);
        state_d = state_q;
        case (state_q)
            RESP_IDLE: begin
                if (request) begin
                    state_d = (WAIT_CYCLES == 0) ? RESP_ACK : RESP_WAIT;
                end
            end
            RESP_WAIT: begin
                // A dropped select wins over an expiring counter.
                if (!request) begin
                    state_d = RESP_IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d = RESP_ACK;
                end
            end
            RESP_ACK: begin
                state_d = RESP_RELEASE;
            end
            RESP_RELEASE: begin
                if (!request) begin
                    state_d = RESP_IDLE;
                end
            end
            default: begin
                state_d = RESP_IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        wdata_d    = wdata_q;
        oor_d      = oor_q;
        data_out_d = data_out_q;

        if ((state_q == RESP_IDLE) && request) begin
            addr_d  = bus.addr_in;
            rw_d    = bus.rw_in;
            wdata_d = bus.data_in;
            cnt_d   = 4'(WAIT_CYCLES);
        end else if ((state_q == RESP_WAIT) && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end

        // With no wait states the commit edge is the request edge itself, so the
        // live bus lines are used instead of the not-yet-latched copies.
        commit   = (state_d == RESP_ACK) && (state_q != RESP_ACK);
        c_addr   = (state_q == RESP_IDLE) ? bus.addr_in : addr_q;
        c_rw     = (state_q == RESP_IDLE) ? bus.rw_in   : rw_q;
        c_data   = (state_q == RESP_IDLE) ? bus.data_in : wdata_q;
        in_range = c_addr < ADDR_W'(NREGS);
        bus_we   = commit && (c_rw == RW_INOUT_W) && in_range;

        if (commit) begin
            oor_d = !in_range;
            if (c_rw == RW_INOUT_R) begin
                data_out_d = in_range ? rd_data : '0;
            end
        end

        ready_d = (state_q == RESP_ACK);
        err_d   = (state_q == RESP_ACK) && oor_q;
    end

    xsim_resp_regbank #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regbank (
        .clk      (clk),
        .rst      (rst),
        .bus_we   (bus_we),
        .bus_idx  (c_addr[IDX_W-1:0]),
        .bus_data (c_data),
        .hw_we    (hw_we_in),
        .hw_idx   (hw_idx_in),
        .hw_data  (hw_data_in),
        .rd_idx   (c_addr[IDX_W-1:0]),
        .rd_data  (rd_data),
        .regs_out (regs_out)
    );

    assign bus.data_out  = data_out_q;
    assign bus.ready_out = ready_q;
    assign bus.err_out   = err_q;

endmodule

// File: tb/tb_xsim_bus_responder.sv
// tb/tb_xsim_bus_responder.sv - self-checking bench for xsim_bus_responder
module tb_xsim_bus_responder;
    import xsim_bus_responder_pkg::*;

    localparam int DW = 8;
    localparam int AW = 27;
    localparam int NR = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst2, rst0;
    logic           hw_we2, hw_we0;
    logic [2:0]     hw_idx2, hw_idx0;
    logic [DW-1:0]  hw_data2, hw_data0;
    logic [NR*DW-1:0] regs2, regs0;

    xsim_bus_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();
    xsim_bus_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();

    xsim_bus_responder #(.DATA_W(DW), .ADDR_W(AW), .NREGS(NR), .WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst2), .bus(bus2),
        .hw_we_in(hw_we2), .hw_idx_in(hw_idx2), .hw_data_in(hw_data2), .regs_out(regs2)
    );

    xsim_bus_responder #(.DATA_W(DW), .ADDR_W(AW), .NREGS(NR), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst0), .bus(bus0),
        .hw_we_in(hw_we0), .hw_idx_in(hw_idx0), .hw_data_in(hw_data0), .regs_out(regs0)
    );

    int checks = 0;
    int failures = 0;
    int stray_err = 0;

    logic [7:0] model2 [NR];
    logic [7:0] model0 [NR];

    typedef struct {
        logic        rw;
        logic [26:0] addr;
        logic [7:0]  wdata;
        logic        exp_err;
        logic [7:0]  exp_dout;
    } vec_t;

    vec_t vecs [9];

    always @(negedge clk) begin
        if (!rst2 && bus2.err_out && !bus2.ready_out) stray_err++;
        if (!rst0 && bus0.err_out && !bus0.ready_out) stray_err++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] flat(input logic [7:0] m [NR]);
        logic [63:0] f;
        for (int i = 0; i < NR; i++) f[i*8 +: 8] = m[i];
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit z, input logic [1:0] sel, input logic rw,
                         input logic [26:0] addr, input logic [7:0] data);
        if (z) begin
            bus0.select_in = sel; bus0.rw_in = rw; bus0.addr_in = addr; bus0.data_in = data;
        end else begin
            bus2.select_in = sel; bus2.rw_in = rw; bus2.addr_in = addr; bus2.data_in = data;
        end
    endtask

    function automatic logic rdy(input bit z);
        return z ? bus0.ready_out : bus2.ready_out;
    endfunction

    // Full transaction: request, wait (bounded) for ack, hold select to look for
    // a second ack, then deselect and let the responder return to idle.
    task automatic txn(input bit z, input logic rw, input logic [26:0] addr, input logic [7:0] wdata,
                       output int lat, output logic got_err, output logic [7:0] got_dout,
                       output int extra);
        lat = -1; got_err = 1'bx; got_dout = 'x; extra = 0;
        drive(z, SELECT_AS_DEVICE, rw, addr, wdata);
        for (int c = 0; c < 20; c++) begin
            step();
            if (rdy(z)) begin
                lat      = c;
                got_err  = z ? bus0.err_out  : bus2.err_out;
                got_dout = z ? bus0.data_out : bus2.data_out;
                break;
            end
        end
        for (int c = 0; c < 4; c++) begin
            step();
            if (rdy(z)) extra++;
        end
        drive(z, SELECT_AS_NONE, RW_INOUT_R, '0, '0);
        step();
        step();
    endtask

    initial begin : main
        int lat, extra, acks;
        logic gerr;
        logic [7:0] gdout;

        vecs[0] = '{RW_INOUT_W, 27'h3,       8'hA5, 1'b0, 8'h00};
        vecs[1] = '{RW_INOUT_R, 27'h3,       8'h00, 1'b0, 8'hA5};
        vecs[2] = '{RW_INOUT_R, 27'h100,     8'h00, 1'b1, 8'h00};
        vecs[3] = '{RW_INOUT_W, 27'h4000003, 8'h55, 1'b1, 8'h00};
        vecs[4] = '{RW_INOUT_W, 27'h7,       8'h5A, 1'b0, 8'h00};
        vecs[5] = '{RW_INOUT_R, 27'h7,       8'h00, 1'b0, 8'h5A};
        vecs[6] = '{RW_INOUT_W, 27'h0,       8'hFF, 1'b0, 8'h5A};
        vecs[7] = '{RW_INOUT_R, 27'h8,       8'h00, 1'b1, 8'h00};
        vecs[8] = '{RW_INOUT_R, 27'h0,       8'h00, 1'b0, 8'hFF};

        for (int i = 0; i < NR; i++) begin
            model2[i] = 8'h00;
            model0[i] = 8'h00;
        end

        rst2 = 1'b1; rst0 = 1'b1;
        hw_we2 = 1'b0; hw_idx2 = '0; hw_data2 = '0;
        hw_we0 = 1'b0; hw_idx0 = '0; hw_data0 = '0;
        drive(1'b0, SELECT_AS_NONE, RW_INOUT_R, '0, '0);
        drive(1'b1, SELECT_AS_NONE, RW_INOUT_R, '0, '0);
        step(); step(); step();
        rst2 = 1'b0; rst0 = 1'b0;
        step();

        check("reset_ready2", bus2.ready_out, 1'b0);
        check("reset_err2",   bus2.err_out,   1'b0);
        check("reset_dout2",  bus2.data_out,  8'h00);
        check("reset_regs2",  regs2,          flat(model2));
        check("reset_state2", u_dut2.state_q, RESP_IDLE);
        check("reset_ready0", bus0.ready_out, 1'b0);
        check("reset_regs0",  regs0,          flat(model0));

        for (int v = 0; v < 9; v++) begin
            txn(1'b0, vecs[v].rw, vecs[v].addr, vecs[v].wdata, lat, gerr, gdout, extra);
            if (vecs[v].rw == RW_INOUT_W && !vecs[v].exp_err) model2[vecs[v].addr[2:0]] = vecs[v].wdata;
            check($sformatf("v%0d_latency", v), lat, 3);
            check($sformatf("v%0d_err", v), gerr, vecs[v].exp_err);
            check($sformatf("v%0d_dout", v), gdout, vecs[v].exp_dout);
            check($sformatf("v%0d_extra_ack", v), extra, 0);
            check($sformatf("v%0d_regs", v), regs2, flat(model2));
            check($sformatf("v%0d_dout_hold", v), bus2.data_out, vecs[v].exp_dout);
        end

        // Deselect during WAIT: request at edge 0, select gone before edge 2.
        drive(1'b0, SELECT_AS_DEVICE, RW_INOUT_W, 27'h1, 8'h3C);
        step(); step();
        drive(1'b0, SELECT_AS_NONE, RW_INOUT_R, '0, '0);
        acks = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (bus2.ready_out) acks++;
        end
        check("abort_no_ack", acks, 0);
        check("abort_regs",   regs2, flat(model2));
        check("abort_state",  u_dut2.state_q, RESP_IDLE);

        // Bus write and local write to reg 5 on the same commit edge (edge 2).
        drive(1'b0, SELECT_AS_DEVICE, RW_INOUT_W, 27'h5, 8'h11);
        step(); step();
        hw_we2 = 1'b1; hw_idx2 = 3'd5; hw_data2 = 8'h22;
        step();
        hw_we2 = 1'b0;
        step();
        check("coll_ready", bus2.ready_out, 1'b1);
        drive(1'b0, SELECT_AS_NONE, RW_INOUT_R, '0, '0);
        step(); step();
        model2[5] = 8'h11;
        check("coll_bus_wins", regs2, flat(model2));

        // Bus write to reg 4 while a local write to reg 6 lands on the same edge.
        drive(1'b0, SELECT_AS_DEVICE, RW_INOUT_W, 27'h4, 8'h44);
        step(); step();
        hw_we2 = 1'b1; hw_idx2 = 3'd6; hw_data2 = 8'h22;
        step();
        hw_we2 = 1'b0;
        step();
        check("dual_ready", bus2.ready_out, 1'b1);
        drive(1'b0, SELECT_AS_NONE, RW_INOUT_R, '0, '0);
        step(); step();
        model2[4] = 8'h44;
        model2[6] = 8'h22;
        check("dual_both_land", regs2, flat(model2));

        // Local write while idle.
        hw_we2 = 1'b1; hw_idx2 = 3'd2; hw_data2 = 8'h99;
        step();
        hw_we2 = 1'b0;
        model2[2] = 8'h99;
        check("hw_idle_write", regs2, flat(model2));

        // Zero-wait-state build.
        txn(1'b1, RW_INOUT_W, 27'h2, 8'h3C, lat, gerr, gdout, extra);
        model0[2] = 8'h3C;
        check("w0_write_latency", lat, 1);
        check("w0_write_err", gerr, 1'b0);
        check("w0_write_extra", extra, 0);
        check("w0_write_regs", regs0, flat(model0));
        txn(1'b1, RW_INOUT_R, 27'h2, 8'h00, lat, gerr, gdout, extra);
        check("w0_read_latency", lat, 1);
        check("w0_read_dout", gdout, 8'h3C);
        txn(1'b1, RW_INOUT_R, 27'h40, 8'h00, lat, gerr, gdout, extra);
        check("w0_oor_err", gerr, 1'b1);
        check("w0_oor_dout", gdout, 8'h00);

        // Reset while in ACK: commit happens at edge 0, reset at edge 1.
        drive(1'b1, SELECT_AS_DEVICE, RW_INOUT_W, 27'h4, 8'h66);
        step();
        model0[4] = 8'h66;
        check("w0_ack_state", u_dut0.state_q, RESP_ACK);
        check("w0_ack_commit", regs0, flat(model0));
        rst0 = 1'b1;
        step();
        for (int i = 0; i < NR; i++) model0[i] = 8'h00;
        check("rst_ack_ready", bus0.ready_out, 1'b0);
        check("rst_ack_regs",  regs0, flat(model0));
        check("rst_ack_dout",  bus0.data_out, 8'h00);
        rst0 = 1'b0;
        drive(1'b1, SELECT_AS_NONE, RW_INOUT_R, '0, '0);
        step();

        check("err_only_with_ready", stray_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
